// File: rtl/serial_pkg.sv
`default_nettype none
//============================================================================
// Module      : serial_pkg
// Description : Shared definitions for the serial transmit path: FSM state
//               encoding, frame geometry, line idle level, default baud
//               divisor and an even-parity helper.
// Revision    : 1.0 - initial release
//============================================================================
package serial_pkg;

    // The encoding is fixed, so PARITY keeps its slot even when unused.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    localparam int   UART_DATA_BITS         = 8;
    localparam logic c_LINE_IDLE            = 1'b1;
    localparam int   c_DEFAULT_CLKS_PER_BIT = 434;   // 50 MHz / 115200

    // Even parity: the bit that makes the total count of ones even.
    function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] data);
        return ^data;
    endfunction

endpackage : serial_pkg
`default_nettype wire

// File: rtl/serial_fifo.sv
`default_nettype none
//============================================================================
// Module      : serial_fifo
// Description : Synchronous circular-buffer FIFO. Pushes into a full FIFO and
//               pops from an empty FIFO are ignored; full/empty are judged
//               on the pre-edge count.
// Ports       : clk, rst (sync, active-high)
//               i_push, i_data   - write request and data
//               i_pop            - read request (o_data is the head entry)
//               o_data           - head of FIFO (valid when !o_empty)
//               o_full, o_empty  - status flags from the count
//               o_count          - occupancy, 0 .. 2**DEPTH_LOG2
// Revision    : 1.0 - initial release
//============================================================================
module serial_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int WIDTH      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_push,
    input  logic [WIDTH-1:0]      i_data,
    input  logic                  i_pop,
    output logic [WIDTH-1:0]      o_data,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [DEPTH_LOG2:0]   o_count
);

    localparam logic [DEPTH_LOG2:0] c_FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [WIDTH-1:0]      r_mem [0:(1<<DEPTH_LOG2)-1];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;

    logic w_full;
    logic w_empty;
    logic w_do_push;
    logic w_do_pop;

    assign w_full    = (r_count == c_FULL_COUNT);
    assign w_empty   = (r_count == '0);
    assign w_do_push = i_push && !w_full;
    assign w_do_pop  = i_pop  && !w_empty;

    // Storage carries no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers wrap naturally modulo the power-of-two depth.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_count = r_count;

endmodule : serial_fifo
`default_nettype wire

// File: rtl/serial_tx_uart.sv
`default_nettype none
//============================================================================
// Module      : serial_tx_uart
// Description : Buffers bytes from the processor serial port in a FIFO and
//               serialises them onto an 8N1 UART line, LSB first. Frames
//               run back-to-back with no idle gap while data is queued.
//               Optional macro SERIAL_TX_PARITY_EN adds an even-parity bit
//               between the data bits and the stop bit (8E1).
// Ports       : clock, reset     - system clock, sync active-high reset
//               serial_in        - byte to send
//               serial_wren_in   - write strobe, one byte per high cycle
//               serial_ready_out - FIFO can accept a byte
//               tx_out           - registered UART line, idles high
//               tx_busy_out      - frame in flight or FIFO non-empty
//               overflow_out     - sticky: a write was dropped while full
// Revision    : 1.0 - initial release
//============================================================================
module serial_tx_uart
    import serial_pkg::*;
#(
    parameter int CLKS_PER_BIT    = c_DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH_LOG2 = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [UART_DATA_BITS-1:0] serial_in,
    input  logic                      serial_wren_in,
    output logic                      serial_ready_out,
    output logic                      tx_out,
    output logic                      tx_busy_out,
    output logic                      overflow_out
);

    localparam int                    c_BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam logic [c_BAUD_W-1:0]   c_BAUD_LAST = c_BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]            c_LAST_BIT  = 3'(UART_DATA_BITS - 1);

    tx_state_t                 r_state,    w_state_next;
    logic [c_BAUD_W-1:0]       r_baud_cnt, w_baud_next;
    logic [2:0]                r_bit_idx,  w_bit_idx_next;
    logic [UART_DATA_BITS-1:0] r_shift,    w_shift_next;
    logic                      r_tx,       w_tx_next;
    logic                      r_overflow;
    logic                      w_baud_done;
    logic                      w_load;

    logic                      w_fifo_pop;
    logic [UART_DATA_BITS-1:0] w_fifo_data;
    logic                      w_fifo_full;
    logic                      w_fifo_empty;
    logic [FIFO_DEPTH_LOG2:0]  w_fifo_count;

`ifdef SERIAL_TX_PARITY_EN
    logic                      r_parity,   w_parity_next;
`endif

    serial_fifo #(
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2),
        .WIDTH      (UART_DATA_BITS)
    ) u_fifo (
        .clk     (clock),
        .rst     (reset),
        .i_push  (serial_wren_in),
        .i_data  (serial_in),
        .i_pop   (w_fifo_pop),
        .o_data  (w_fifo_data),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    assign w_baud_done = (r_baud_cnt == c_BAUD_LAST);

    always_comb begin
        w_state_next   = r_state;
        w_baud_next    = r_baud_cnt + 1'b1;
        w_bit_idx_next = r_bit_idx;
        w_shift_next   = r_shift;
        w_fifo_pop     = 1'b0;
        w_load         = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_baud_next = '0;
                if (!w_fifo_empty) begin
                    w_load       = 1'b1;
                    w_state_next = ST_START;
                end
            end
            ST_START: begin
                if (w_baud_done) begin
                    w_baud_next    = '0;
                    w_bit_idx_next = '0;
                    w_state_next   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_baud_done) begin
                    w_baud_next    = '0;
                    w_shift_next   = r_shift >> 1;
                    w_bit_idx_next = r_bit_idx + 3'd1;
                    if (r_bit_idx == c_LAST_BIT) begin
`ifdef SERIAL_TX_PARITY_EN
                        w_state_next = ST_PARITY;
`else
                        w_state_next = ST_STOP;
`endif
                    end
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            ST_PARITY: begin
                if (w_baud_done) begin
                    w_baud_next  = '0;
                    w_state_next = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (w_baud_done) begin
                    w_baud_next = '0;
                    // Chain straight into the next START to avoid an idle gap.
                    if (!w_fifo_empty) begin
                        w_load       = 1'b1;
                        w_state_next = ST_START;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end
            end
            default: begin
                w_baud_next  = '0;
                w_state_next = ST_IDLE;
            end
        endcase

        if (w_load) begin
            w_fifo_pop   = 1'b1;
            w_shift_next = w_fifo_data;
        end
    end

`ifdef SERIAL_TX_PARITY_EN
    // Latched at pop time because the shift register is consumed by DATA.
    assign w_parity_next = w_load ? even_parity(w_fifo_data) : r_parity;
`endif

    // Line level is decoded from the next state so tx_out is a flop output.
    always_comb begin
        case (w_state_next)
            ST_START:  w_tx_next = 1'b0;
            ST_DATA:   w_tx_next = w_shift_next[0];
`ifdef SERIAL_TX_PARITY_EN
            ST_PARITY: w_tx_next = w_parity_next;
`endif
            default:   w_tx_next = c_LINE_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_tx       <= c_LINE_IDLE;
            r_overflow <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
            r_parity   <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_next;
            r_baud_cnt <= w_baud_next;
            r_bit_idx  <= w_bit_idx_next;
            r_shift    <= w_shift_next;
            r_tx       <= w_tx_next;
            r_overflow <= r_overflow | (serial_wren_in && w_fifo_full);
`ifdef SERIAL_TX_PARITY_EN
            r_parity   <= w_parity_next;
`endif
        end
    end

    assign serial_ready_out = !w_fifo_full;
    assign tx_out           = r_tx;
    assign tx_busy_out      = (r_state != ST_IDLE) || (w_fifo_count != '0);
    assign overflow_out     = r_overflow;

endmodule : serial_tx_uart
`default_nettype wire

// File: tb/tb_serial_tx_uart.sv
`default_nettype none
//============================================================================
// Module      : tb_serial_tx_uart
// Description : Directed self-checking bench for serial_tx_uart with
//               CLKS_PER_BIT=4 and a 4-entry FIFO. A line receiver decodes
//               every frame, checks each bit is held for its full period and
//               records the byte and the cycle its start bit appeared.
// Revision    : 1.0 - initial release
//============================================================================
module tb_serial_tx_uart;

    localparam int CPB = 4;
    localparam int DL2 = 2;
`ifdef SERIAL_TX_PARITY_EN
    localparam int BITS_PER_FRAME = 11;
`else
    localparam int BITS_PER_FRAME = 10;
`endif
    localparam int FRAME = CPB * BITS_PER_FRAME;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] serial_in = 8'h00;
    logic       serial_wren_in = 1'b0;
    logic       serial_ready_out;
    logic       tx_out;
    logic       tx_busy_out;
    logic       overflow_out;

    serial_tx_uart #(
        .CLKS_PER_BIT    (CPB),
        .FIFO_DEPTH_LOG2 (DL2)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .serial_in        (serial_in),
        .serial_wren_in   (serial_wren_in),
        .serial_ready_out (serial_ready_out),
        .tx_out           (tx_out),
        .tx_busy_out      (tx_busy_out),
        .overflow_out     (overflow_out)
    );

    always #5 clock = ~clock;

    // cyc == k at the negedge following rising edge k.
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // ---------------- line receiver ----------------
    logic [7:0] rx_q[$];
    int         rx_t[$];
    logic       rx_par[$];
    int         rx_err = 0;

    initial begin : p_rx
        logic [7:0] d;
        logic       par;
        logic       exp_lvl;
        bit         aborted;
        int         t0;
        int         bit_no;
        forever begin
            @(negedge clock);
            if (!reset && tx_out == 1'b0) begin
                t0 = cyc; d = '0; par = 1'b0; aborted = 1'b0;
                for (int i = 0; i < FRAME; i++) begin
                    if (i > 0) @(negedge clock);
                    if (reset) begin
                        aborted = 1'b1;
                        break;
                    end
                    bit_no = i / CPB;
                    if (bit_no == 0) begin
                        exp_lvl = 1'b0;
                    end else if (bit_no <= 8) begin
                        if (i % CPB == 0) d[bit_no-1] = tx_out;
                        exp_lvl = d[bit_no-1];
                    end else if (bit_no == BITS_PER_FRAME - 1) begin
                        exp_lvl = 1'b1;
                    end else begin
                        if (i % CPB == 0) par = tx_out;
                        exp_lvl = par;
                    end
                    if (tx_out !== exp_lvl) rx_err++;
                end
                if (!aborted) begin
                    rx_q.push_back(d);
                    rx_t.push_back(t0);
                    rx_par.push_back(par);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(negedge clock);
        #1;
    endtask

    task automatic wait_until(input int k);
        while (cyc < k) step();
    endtask

    task automatic write_byte(input logic [7:0] b, output int edge_n);
        serial_in      = b;
        serial_wren_in = 1'b1;
        step();
        serial_wren_in = 1'b0;
        edge_n         = cyc;
    endtask

    task automatic clear_rx();
        rx_q.delete();
        rx_t.delete();
        rx_par.delete();
    endtask

    initial begin : p_watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- directed tests ----------------
    initial begin : p_main
        int         n;
        int         s;
        logic [7:0] ovf_bytes [5];
        logic [7:0] line_bytes [6];

        ovf_bytes  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        line_bytes = '{8'hA5, 8'h11, 8'h22, 8'h33, 8'h44, 8'h5A};

        // Reset state
        repeat (3) step();
        check_eq("rst_tx",    tx_out,           1);
        check_eq("rst_ready", serial_ready_out, 1);
        check_eq("rst_busy",  tx_busy_out,      0);
        check_eq("rst_ovf",   overflow_out,     0);
        reset = 1'b0;
        step();

        // Basic frame: 0x48
        write_byte(8'h48, n);
        check_eq("basic_busy_on_write", tx_busy_out, 1);
        check_eq("basic_tx_idle_n",     tx_out,      1);
        step();
        check_eq("basic_start_low",     tx_out,      0);
        wait_until(n + FRAME);
        check_eq("basic_busy_last",     tx_busy_out, 1);
        check_eq("basic_stop_high",     tx_out,      1);
        step();
        check_eq("basic_busy_drop",     tx_busy_out, 0);
        check_eq("basic_rx_count",      rx_q.size(), 1);
        check_eq("basic_rx_byte",       rx_q[0],     8'h48);
        check_eq("basic_rx_start",      rx_t[0],     n + 1);
        check_eq("basic_rx_err",        rx_err,      0);
`ifdef SERIAL_TX_PARITY_EN
        check_eq("basic_parity",        rx_par[0],   0);
`endif
        clear_rx();

        // Back-to-back "Hi"
        serial_in = 8'h48; serial_wren_in = 1'b1;
        step();
        n = cyc;
        serial_in = 8'h69;
        step();
        serial_wren_in = 1'b0;
        wait_until(n + 2 * FRAME);
        check_eq("b2b_busy_last", tx_busy_out, 1);
        step();
        check_eq("b2b_busy_drop", tx_busy_out, 0);
        check_eq("b2b_rx_count",  rx_q.size(), 2);
        check_eq("b2b_byte0",     rx_q[0],     8'h48);
        check_eq("b2b_byte1",     rx_q[1],     8'h69);
        check_eq("b2b_start0",    rx_t[0],     n + 1);
        check_eq("b2b_start1",    rx_t[1],     n + 1 + FRAME);
        check_eq("b2b_rx_err",    rx_err,      0);
        clear_rx();

        // Full / overflow with a frame already in flight
        write_byte(8'hA5, n);
        s = n + 1;
        step();
        step();
        check_eq("ovf_ready_empty", serial_ready_out, 1);
        serial_wren_in = 1'b1;
        for (int k = 0; k < 5; k++) begin
            serial_in = ovf_bytes[k];
            step();
            if (k == 2) check_eq("ovf_ready_3",  serial_ready_out, 1);
            if (k == 3) begin
                check_eq("ovf_ready_full", serial_ready_out, 0);
                check_eq("ovf_flag_clear", overflow_out,     0);
            end
        end
        serial_wren_in = 1'b0;
        check_eq("ovf_flag_set",     overflow_out,     1);
        check_eq("ovf_still_full",   serial_ready_out, 0);

        // Push while full on the same edge as the pop: dropped, count 4 -> 3
        wait_until(s + FRAME - 1);
        check_eq("pp_full_before",   serial_ready_out, 0);
        serial_in = 8'hEE; serial_wren_in = 1'b1;
        step();
        serial_wren_in = 1'b0;
        check_eq("pp_full_ready_after", serial_ready_out, 1);
        check_eq("pp_ovf_sticky",       overflow_out,     1);

        // Push and pop together at count 2: both happen
        wait_until(s + 3 * FRAME - 1);
        serial_in = 8'h5A; serial_wren_in = 1'b1;
        step();
        serial_wren_in = 1'b0;
        check_eq("pp2_ready", serial_ready_out, 1);

        wait_until(s + 6 * FRAME - 1);
        check_eq("ovf_busy_last", tx_busy_out, 1);
        step();
        check_eq("ovf_busy_drop", tx_busy_out, 0);
        check_eq("ovf_rx_count",  rx_q.size(), 6);
        for (int k = 0; k < 6; k++) begin
            check_eq($sformatf("ovf_byte%0d", k),  rx_q[k], line_bytes[k]);
            check_eq($sformatf("ovf_start%0d", k), rx_t[k], s + k * FRAME);
        end
        check_eq("ovf_rx_err",    rx_err,       0);
        check_eq("ovf_flag_keep", overflow_out, 1);
        clear_rx();

        // Reset during DATA bit 3, with a second byte queued
        serial_in = 8'hC3; serial_wren_in = 1'b1;
        step();
        n = cyc;
        serial_in = 8'h0F;
        step();
        serial_wren_in = 1'b0;
        s = n + 1;
        wait_until(s + 4 * CPB);
        reset = 1'b1;
        step();
        check_eq("mid_rst_tx",    tx_out,           1);
        check_eq("mid_rst_ready", serial_ready_out, 1);
        check_eq("mid_rst_busy",  tx_busy_out,      0);
        check_eq("mid_rst_ovf",   overflow_out,     0);
        step();
        reset = 1'b0;
        wait_until(cyc + 2 * FRAME);
        check_eq("mid_rst_no_frame", rx_q.size(), 0);
        check_eq("mid_rst_idle_tx",  tx_out,      1);
        check_eq("mid_rst_idle_busy", tx_busy_out, 0);
        write_byte(8'h55, n);
        wait_until(n + FRAME + 1);
        check_eq("post_rst_count", rx_q.size(), 1);
        check_eq("post_rst_byte",  rx_q[0],     8'h55);
        check_eq("post_rst_start", rx_t[0],     n + 1);
        check_eq("post_rst_err",   rx_err,      0);
        clear_rx();

`ifdef SERIAL_TX_PARITY_EN
        // Parity bits: 0x07 -> 1, 0x03 -> 0; 44-cycle frames
        serial_in = 8'h07; serial_wren_in = 1'b1;
        step();
        n = cyc;
        serial_in = 8'h03;
        step();
        serial_wren_in = 1'b0;
        wait_until(n + 2 * FRAME + 1);
        check_eq("par_count", rx_q.size(), 2);
        check_eq("par_byte0", rx_q[0],     8'h07);
        check_eq("par_bit0",  rx_par[0],   1);
        check_eq("par_byte1", rx_q[1],     8'h03);
        check_eq("par_bit1",  rx_par[1],   0);
        check_eq("par_frame_len", rx_t[1] - rx_t[0], 44);
        check_eq("par_rx_err", rx_err, 0);
        clear_rx();
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_serial_tx_uart
`default_nettype wire

// File: doc/serial_tx_uart.md
Name: serial_tx_uart

Overview:
- Downstream consumer of the processor's serial output port.
- Accepts bytes written by the data_memory serial path (serial_out / serial_wren_out) and buffers them in a small FIFO.
- Serialises each byte onto an 8N1 UART line, LSB first.
- Returns back-pressure to the processor through its serial_ready_in input.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); legal range 2..65535.
- FIFO_DEPTH_LOG2, 4, log2 of FIFO depth (default 16 entries); legal range 1..8.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- serial_in  input  8  byte to transmit (from processor serial_out).
- serial_wren_in  input  1  write strobe (from processor serial_wren_out); one byte per high cycle.
- serial_ready_out  output  1  high when the FIFO can accept a byte (to processor serial_ready_in).
- tx_out  output  1  UART line; idles high.
- tx_busy_out  output  1  high while a frame is in flight or the FIFO is non-empty.
- overflow_out  output  1  sticky flag: a write was dropped because the FIFO was full.

Behaviour:
- Reset values, taking effect on the first rising edge with reset=1:
  - tx_out=1, serial_ready_out=1, tx_busy_out=0, overflow_out=0.
  - FIFO emptied (read/write pointers and count all 0); FSM=IDLE; bit counter and baud counter = 0.
  - Reset mid-frame aborts the frame; tx_out is 1 from that edge onward.
- FIFO:
  - Circular buffer, registered pointers of FIFO_DEPTH_LOG2 bits that wrap modulo depth; count is FIFO_DEPTH_LOG2+1 bits.
  - serial_ready_out = !full (combinational from count).
  - A write occurs when serial_wren_in && !full.
  - serial_wren_in while full: the byte is dropped and overflow_out is set (it clears only on reset).
  - Simultaneous push and pop: when full, the push is dropped because full is judged on the pre-edge count. When not full, both occur and count is unchanged.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if FIFO non-empty, pop the head into shift register, baud_cnt=0, go to START. Otherwise stay; tx_out=1.
  - START: tx_out=0 for CLKS_PER_BIT cycles, then DATA with bit_idx=0.
  - DATA: tx_out=shift[0] for CLKS_PER_BIT cycles per bit. At the end of each bit, shift right and bit_idx++. After bit_idx=7 completes, go to STOP.
  - STOP: tx_out=1 for CLKS_PER_BIT cycles, then IDLE. The next byte's START can begin on the cycle after STOP ends, so back-to-back frames have no extra idle gap.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1; terminal count advances the bit.
  - Resets to 0 on every state entry.
- tx_out is registered (no glitches).
- Latency: a write at edge N makes the FIFO non-empty after N. The pop happens at edge N+1, and tx_out goes low after edge N+1.
- Frame length: exactly 10*CLKS_PER_BIT cycles.
- tx_busy_out = (state != IDLE) || !empty.

Optional Feature:
- Macro: SERIAL_TX_PARITY_EN.
- When defined: a PARITY state is inserted between DATA and STOP. It drives the even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles, giving a frame of 11*CLKS_PER_BIT cycles.
- When undefined: 8N1 only; the PARITY state and parity logic are absent.

Decomposition:
- Package serial_pkg holds:
  - the FSM state encoding (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4);
  - UART_DATA_BITS=8;
  - the line idle level constant;
  - the default CLKS_PER_BIT.
- One sub-module: serial_fifo (parameterised synchronous FIFO with push/pop/full/empty/count).
- The FSM and baud counter stay in serial_tx_uart.

Test Plan:
- Basic frame: CLKS_PER_BIT=4; write 8'h48 -> tx_out reads 0, 0,0,0,1,0,0,1,0, 1, each bit held 4 cycles. Frame lasts 40 cycles; tx_busy_out drops one cycle after the stop bit ends.
- Back-to-back: write "Hi" (8'h48, 8'h69) on consecutive cycles -> two frames with no gap; 80 cycles total from the first start bit.
- Full / overflow: FIFO_DEPTH_LOG2=2; write 5 bytes in 5 cycles with the FSM stalled in its first frame -> serial_ready_out=0 after the 4th write is accepted. The 5th byte is dropped and overflow_out=1. The line then carries bytes 1–4 only.
- Simultaneous push/pop at full: count=4, FSM popping on the same edge as a write -> write dropped, count=3. Push/pop at count=2 -> count stays 2.
- Reset mid-frame: assert reset during DATA bit 3 -> tx_out=1 from the next edge, FIFO empty, serial_ready_out=1. A new write of 8'h55 afterwards produces a clean frame.
- Parity (SERIAL_TX_PARITY_EN): write 8'h07 -> parity bit 1, then stop bit; write 8'h03 -> parity bit 0; frame length 44 cycles at CLKS_PER_BIT=4.
